// File: rtl/snake_pkg.sv
// Shared definitions for the snake renderer: direction codes, colour masks
// and the reverse-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    // One bit per channel; the top widens each bit to a full-scale channel.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_mask_t;

    localparam rgb_mask_t HEAD_RGB = 3'b010;
    localparam rgb_mask_t BODY_RGB = 3'b100;
    localparam rgb_mask_t BG_RGB   = 3'b000;

    // Opposite directions differ only in the MSB of the encoding.
    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_renderer_if.sv
// Controller-side bundle of the snake renderer: raster/move controls in,
// pixel colour and snake status out.
interface snake_renderer_if #(
    parameter int CELL_W  = 6,
    parameter int COLOR_W = 4,
    parameter int LEN_W   = 5
);
    logic               TRANSMIT;
    logic               MOVE;
    logic [1:0]         DIR;
    logic [LEN_W-1:0]   LEN;
    logic [COLOR_W-1:0] DATA_R;
    logic [COLOR_W-1:0] DATA_G;
    logic [COLOR_W-1:0] DATA_B;
    logic [CELL_W-1:0]  HEAD_X;
    logic [CELL_W-1:0]  HEAD_Y;
    logic               MOVE_PENDING;
    logic               FRAME_DONE;
    logic               COLLIDE;

    modport master (
        output TRANSMIT, MOVE, DIR, LEN,
        input  DATA_R, DATA_G, DATA_B, HEAD_X, HEAD_Y, MOVE_PENDING, FRAME_DONE, COLLIDE
    );

    modport slave (
        input  TRANSMIT, MOVE, DIR, LEN,
        output DATA_R, DATA_G, DATA_B, HEAD_X, HEAD_Y, MOVE_PENDING, FRAME_DONE, COLLIDE
    );
endinterface

// File: rtl/snake_body_buffer.sv
// Segment history shift register with wrap-around head stepping, cell hit
// compare and (with SNAKE_COLLISION_DETECT_EN) the self-collision compare.
module snake_body_buffer
    import snake_pkg::*;
#(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int CELL_W   = 6,
    parameter int MAX_SEGS = 16,
    parameter int LEN_W    = 5,
    parameter int START_X  = 32,
    parameter int START_Y  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              apply,
    input  logic              len_load,
    input  dir_e              step_dir,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [CELL_W-1:0] query_x,
    input  logic [CELL_W-1:0] query_y,
    output logic              head_hit,
    output logic              body_hit,
    output logic              self_hit,
    output logic [CELL_W-1:0] head_x,
    output logic [CELL_W-1:0] head_y
);
    logic [CELL_W-1:0] seg_x_q [MAX_SEGS];
    logic [CELL_W-1:0] seg_x_d [MAX_SEGS];
    logic [CELL_W-1:0] seg_y_q [MAX_SEGS];
    logic [CELL_W-1:0] seg_y_d [MAX_SEGS];
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CELL_W-1:0] new_x, new_y;

    // Reset lays the body out to the left of the head, wrapping at column 0.
    function automatic logic [CELL_W-1:0] reset_x(input int idx);
        logic [CELL_W-1:0] x;
        x = CELL_W'(START_X);
        for (int k = 0; k < MAX_SEGS; k++)
            if (k < idx) x = (x == '0) ? CELL_W'(GRID_W - 1) : x - CELL_W'(1);
        return x;
    endfunction

    always_comb begin
        new_x = seg_x_q[0];
        new_y = seg_y_q[0];
        case (step_dir)
            DIR_RIGHT: new_x = (seg_x_q[0] == CELL_W'(GRID_W - 1)) ? '0 : seg_x_q[0] + CELL_W'(1);
            DIR_LEFT:  new_x = (seg_x_q[0] == '0) ? CELL_W'(GRID_W - 1) : seg_x_q[0] - CELL_W'(1);
            DIR_DOWN:  new_y = (seg_y_q[0] == CELL_W'(GRID_H - 1)) ? '0 : seg_y_q[0] + CELL_W'(1);
            DIR_UP:    new_y = (seg_y_q[0] == '0) ? CELL_W'(GRID_H - 1) : seg_y_q[0] - CELL_W'(1);
            default:   ;
        endcase

        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        len_d   = len_load ? len_in : len_q;
        if (apply) begin
            seg_x_d[0] = new_x;
            seg_y_d[0] = new_y;
            for (int i = 1; i < MAX_SEGS; i++) begin
                seg_x_d[i] = seg_x_q[i-1];
                seg_y_d[i] = seg_y_q[i-1];
            end
        end

        head_hit = (query_x == seg_x_q[0]) && (query_y == seg_y_q[0]);
        body_hit = 1'b0;
        for (int i = 1; i < MAX_SEGS; i++)
            if (i < int'(len_q) && query_x == seg_x_q[i] && query_y == seg_y_q[i]) body_hit = 1'b1;

        // Old segments 0..len-2 become the new body after the shift.
        self_hit = 1'b0;
`ifdef SNAKE_COLLISION_DETECT_EN
        for (int i = 0; i < MAX_SEGS - 1; i++)
            if ((i + 1) < int'(len_in) && new_x == seg_x_q[i] && new_y == seg_y_q[i]) self_hit = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_SEGS; i++) begin
                seg_x_q[i] <= reset_x(i);
                seg_y_q[i] <= CELL_W'(START_Y);
            end
            len_q <= LEN_W'(1);
        end else begin
            seg_x_q <= seg_x_d;
            seg_y_q <= seg_y_d;
            len_q   <= len_d;
        end
    end

    assign head_x = seg_x_q[0];
    assign head_y = seg_y_q[0];

endmodule

// File: rtl/snake_renderer.sv
// Raster walker that paints a multi-segment snake on a cell grid; moves are
// applied at frame wrap. Define SNAKE_COLLISION_DETECT_EN for sticky self-collision.
module snake_renderer
    import snake_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SEG_SIZE = 10,
    parameter int CELL_W   = 6,
    parameter int MAX_SEGS = 16,
    parameter int COLOR_W  = 4,
    parameter int START_X  = 32,
    parameter int START_Y  = 24
) (
    input  logic            CLK,
    input  logic            RST,
    snake_renderer_if.slave io
);
    localparam int GRID_W = H_ACTIVE / SEG_SIZE;
    localparam int GRID_H = V_ACTIVE / SEG_SIZE;
    localparam int LEN_W  = $clog2(MAX_SEGS) + 1;
    localparam int HCNT_W = $clog2(H_ACTIVE + 1);
    localparam int VCNT_W = $clog2(V_ACTIVE + 1);
    localparam int SUB_W  = $clog2(SEG_SIZE + 1);

    logic [HCNT_W-1:0]  hcount_q, hcount_d;
    logic [VCNT_W-1:0]  vcount_q, vcount_d;
    logic [SUB_W-1:0]   hsub_q, hsub_d, vsub_q, vsub_d;
    logic [CELL_W-1:0]  cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    logic [COLOR_W-1:0] data_r_q, data_r_d, data_g_q, data_g_d, data_b_q, data_b_d;
    logic               pending_q, pending_d, frame_done_q, frame_done_d, collide_q, collide_d;
    dir_e               dir_q, dir_d, move_dir;
    logic [LEN_W-1:0]   len_clamped;
    logic               line_end, frame_end, wrap, apply_move;
    logic               head_hit, body_hit, self_hit;
    logic [CELL_W-1:0]  head_x, head_y;
    rgb_mask_t          pix_mask;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
        if (req == '0) return LEN_W'(1);
        if (req > LEN_W'(MAX_SEGS)) return LEN_W'(MAX_SEGS);
        return req;
    endfunction

    // Raster walk with sub-cell counters so the cell index needs no divider.
    always_comb begin
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        hsub_d    = hsub_q;
        vsub_d    = vsub_q;
        cell_x_d  = cell_x_q;
        cell_y_d  = cell_y_q;
        line_end  = (hcount_q == HCNT_W'(H_ACTIVE - 1));
        frame_end = line_end && (vcount_q == VCNT_W'(V_ACTIVE - 1));
        if (io.TRANSMIT) begin
            if (line_end) begin
                hcount_d = '0;
                hsub_d   = '0;
                cell_x_d = '0;
                if (frame_end) begin
                    vcount_d = '0;
                    vsub_d   = '0;
                    cell_y_d = '0;
                end else begin
                    vcount_d = vcount_q + VCNT_W'(1);
                    if (vsub_q == SUB_W'(SEG_SIZE - 1)) begin
                        vsub_d   = '0;
                        cell_y_d = cell_y_q + CELL_W'(1);
                    end else begin
                        vsub_d = vsub_q + SUB_W'(1);
                    end
                end
            end else begin
                hcount_d = hcount_q + HCNT_W'(1);
                if (hsub_q == SUB_W'(SEG_SIZE - 1)) begin
                    hsub_d   = '0;
                    cell_x_d = cell_x_q + CELL_W'(1);
                end else begin
                    hsub_d = hsub_q + SUB_W'(1);
                end
            end
        end
    end

    // Snake state only changes at frame wrap, keeping each frame stable.
    always_comb begin
        wrap         = io.TRANSMIT && frame_end;
        apply_move   = wrap && pending_q && !collide_q;
        len_clamped  = clamp_len(io.LEN);
        move_dir     = (dir_e'(io.DIR) == reverse_dir(dir_q)) ? dir_q : dir_e'(io.DIR);
        dir_d        = apply_move ? move_dir : dir_q;
        pending_d    = wrap ? io.MOVE : (pending_q || io.MOVE);
        frame_done_d = wrap;
        collide_d    = collide_q || (apply_move && self_hit);
        pix_mask     = head_hit ? HEAD_RGB : (body_hit ? BODY_RGB : BG_RGB);
        data_r_d     = {COLOR_W{pix_mask.r}};
        data_g_d     = {COLOR_W{pix_mask.g}};
        data_b_d     = {COLOR_W{pix_mask.b}};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hcount_q     <= '0;
            vcount_q     <= '0;
            hsub_q       <= '0;
            vsub_q       <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            data_r_q     <= '0;
            data_g_q     <= '0;
            data_b_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            collide_q    <= 1'b0;
            dir_q        <= DIR_RIGHT;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hsub_q       <= hsub_d;
            vsub_q       <= vsub_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            data_r_q     <= data_r_d;
            data_g_q     <= data_g_d;
            data_b_q     <= data_b_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            collide_q    <= collide_d;
            dir_q        <= dir_d;
        end
    end

    snake_body_buffer #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .CELL_W   (CELL_W),
        .MAX_SEGS (MAX_SEGS),
        .LEN_W    (LEN_W),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) u_body (
        .clk      (CLK),
        .rst      (RST),
        .apply    (apply_move),
        .len_load (wrap),
        .step_dir (move_dir),
        .len_in   (len_clamped),
        .query_x  (cell_x_q),
        .query_y  (cell_y_q),
        .head_hit (head_hit),
        .body_hit (body_hit),
        .self_hit (self_hit),
        .head_x   (head_x),
        .head_y   (head_y)
    );

    assign io.DATA_R       = data_r_q;
    assign io.DATA_G       = data_g_q;
    assign io.DATA_B       = data_b_q;
    assign io.HEAD_X       = head_x;
    assign io.HEAD_Y       = head_y;
    assign io.MOVE_PENDING = pending_q;
    assign io.FRAME_DONE   = frame_done_q;
    assign io.COLLIDE      = collide_q;

endmodule

// File: tb/tb_snake_renderer.sv
// Scoreboard bench for snake_renderer on a reduced 48x40 raster (12x10 grid);
// a queue-based reference model predicts every cycle's outputs.
module tb_snake_renderer;
    localparam int H    = 48;
    localparam int V    = 40;
    localparam int SEG  = 4;
    localparam int CW   = 6;
    localparam int MS   = 16;
    localparam int COLW = 4;
    localparam int SX   = 6;
    localparam int SY   = 5;
    localparam int GW   = H / SEG;
    localparam int GH   = V / SEG;
    localparam int LW   = $clog2(MS) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_renderer_if #(.CELL_W(CW), .COLOR_W(COLW), .LEN_W(LW)) io ();

    snake_renderer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SEG_SIZE(SEG), .CELL_W(CW),
        .MAX_SEGS(MS), .COLOR_W(COLW), .START_X(SX), .START_Y(SY)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io)
    );

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [5:0] hx;
        logic [5:0] hy;
        logic       pend;
        logic       fd;
        logic       coll;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference model state: raster position and snake as coordinate queues.
    int m_h, m_v, m_len, m_dir;
    bit m_pend, m_coll, m_wrap;
    int m_sx[$];
    int m_sy[$];
    int cur_dir = 0;
    int cur_len = 1;
    bit rand_tx = 1'b0;

    task automatic check(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, want, $time);
    endtask

    task automatic model_apply(input int req_dir);
        int nd, dx, dy, nx, ny;
        nd = req_dir;
        if (nd == (m_dir + 2) % 4) nd = m_dir;
        dx = (nd == 0) ? 1 : ((nd == 2) ? -1 : 0);
        dy = (nd == 1) ? 1 : ((nd == 3) ? -1 : 0);
        nx = (m_sx[0] + dx + GW) % GW;
        ny = (m_sy[0] + dy + GH) % GH;
`ifdef SNAKE_COLLISION_DETECT_EN
        for (int k = 0; k <= m_len - 2; k++)
            if (m_sx[k] == nx && m_sy[k] == ny) m_coll = 1'b1;
`endif
        m_sx.push_front(nx);
        m_sy.push_front(ny);
        void'(m_sx.pop_back());
        void'(m_sy.pop_back());
        m_dir = nd;
    endtask

    task automatic model_step(input bit r, input bit tx, input bit mv, output exp_t e);
        int cx, cy, l;
        bit hd, bd;
        e = '0;
        m_wrap = 1'b0;
        if (r) begin
            m_h = 0; m_v = 0; m_len = 1; m_dir = 0; m_pend = 0; m_coll = 0;
            m_sx.delete();
            m_sy.delete();
            for (int i = 0; i < MS; i++) begin
                m_sx.push_back(((SX - i) % GW + GW) % GW);
                m_sy.push_back(SY);
            end
        end else begin
            cx = m_h / SEG;
            cy = m_v / SEG;
            hd = (m_sx[0] == cx) && (m_sy[0] == cy);
            bd = 1'b0;
            for (int k = 1; k < m_len; k++)
                if (m_sx[k] == cx && m_sy[k] == cy) bd = 1'b1;
            e.g = hd ? 4'hF : 4'h0;
            e.r = (bd && !hd) ? 4'hF : 4'h0;
            m_wrap = tx && (m_h == H - 1) && (m_v == V - 1);
            e.fd = m_wrap;
            if (m_wrap) begin
                l = cur_len;
                if (l < 1) l = 1;
                if (l > MS) l = MS;
                m_len = l;
                if (m_pend && !m_coll) model_apply(cur_dir);
                m_pend = mv;
            end else begin
                m_pend = m_pend || mv;
            end
            if (tx) begin
                m_h++;
                if (m_h == H) begin
                    m_h = 0;
                    m_v++;
                    if (m_v == V) m_v = 0;
                end
            end
        end
        e.hx   = 6'(m_sx[0]);
        e.hy   = 6'(m_sy[0]);
        e.pend = m_pend;
        e.coll = m_coll;
    endtask

    task automatic tick(input bit r, input bit tx, input bit mv);
        exp_t e;
        rst         = r;
        io.TRANSMIT = tx;
        io.MOVE     = mv;
        io.DIR      = 2'(cur_dir);
        io.LEN      = LW'(cur_len);
        model_step(r, tx, mv, e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input bit rnd_moves);
        int n;
        bit tx, mv;
        n = 0;
        do begin
            tx = rand_tx ? ($urandom_range(9) != 0) : 1'b1;
            mv = rnd_moves && ($urandom_range(299) == 0);
            if (rnd_moves && $urandom_range(499) == 0) cur_dir = $urandom_range(3);
            tick(1'b0, tx, mv);
            n++;
        end while (!m_wrap && n < 4 * H * V);
        if (!m_wrap) begin
            total_cnt++;
            $display("FAIL frame_timeout: no wrap after %0d cycles", n);
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(m_h == h && m_v == v) && n < 2 * H * V) begin
            tick(1'b0, 1'b1, 1'b0);
            n++;
        end
    endtask

    task automatic pix_check(input string name, input int h, input int v, input int r, input int g);
        run_to(h, v);
        tick(1'b0, 1'b1, 1'b0);
        check({name, "_r"}, io.DATA_R, r);
        check({name, "_g"}, io.DATA_G, g);
    endtask

    task automatic do_move(input int d);
        cur_dir = d;
        tick(1'b0, 1'b1, 1'b1);
        run_frame(1'b0);
    endtask

    // Monitor: every cycle the DUT presents a fresh pixel and status word.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("colour", int'({io.DATA_R, io.DATA_G, io.DATA_B}), int'({e.r, e.g, e.b}));
            check("head", int'({io.HEAD_X, io.HEAD_Y}), int'({e.hx, e.hy}));
            check("flags", int'({io.MOVE_PENDING, io.FRAME_DONE, io.COLLIDE}), int'({e.pend, e.fd, e.coll}));
        end
    end

    initial begin
        rst = 1'b1; io.TRANSMIT = 1'b0; io.MOVE = 1'b0; io.DIR = 2'b00; io.LEN = LW'(1);

        // Reset and first frame; length 3 shows from the next frame on.
        cur_len = 3;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("rst_head_x", io.HEAD_X, SX);
        check("rst_head_y", io.HEAD_Y, SY);
        check("rst_data_g", io.DATA_G, 0);
        run_frame(1'b0);
        pix_check("t1_bg", 13, 21, 0, 0);
        pix_check("t1_body2", 17, 21, 15, 0);
        pix_check("t1_body1", 21, 21, 15, 0);
        pix_check("t1_head", 25, 21, 0, 15);
        check("t1_head_x", io.HEAD_X, SX);

        // Move handshake.
        run_to(30, 30);
        cur_dir = 0;
        tick(1'b0, 1'b1, 1'b1);
        check("t2_pend", io.MOVE_PENDING, 1);
        check("t2_head_hold", io.HEAD_X, SX);
        run_frame(1'b0);
        check("t2_fd", io.FRAME_DONE, 1);
        check("t2_head", io.HEAD_X, SX + 1);
        check("t2_pend_clr", io.MOVE_PENDING, 0);
        tick(1'b0, 1'b1, 1'b0);
        check("t2_fd_pulse", io.FRAME_DONE, 0);

        // Reversal is ignored.
        do_move(2);
        check("t3_reverse", io.HEAD_X, SX + 2);

        // Right-edge wrap.
        for (int i = 0; i < GW - 1 - (SX + 2); i++) do_move(0);
        check("t4_edge", io.HEAD_X, GW - 1);
        do_move(0);
        check("t4_wrap", io.HEAD_X, 0);
        pix_check("t4_pix", 1, 21, 0, 15);

        // Stall, then reset mid-frame with a move pending.
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("t5_pend", io.MOVE_PENDING, 1);
        tick(1'b1, 1'b1, 1'b0);
        check("t5_head_x", io.HEAD_X, SX);
        check("t5_head_y", io.HEAD_Y, SY);
        check("t5_pend", io.MOVE_PENDING, 0);
        check("t5_fd", io.FRAME_DONE, 0);

        // Turn back onto the body.
        cur_len = 5;
        do_move(1);
        do_move(2);
        do_move(3);
        check("t6_head_x", io.HEAD_X, SX - 1);
        check("t6_head_y", io.HEAD_Y, SY);
`ifdef SNAKE_COLLISION_DETECT_EN
        check("t6_collide", io.COLLIDE, 1);
        do_move(0);
        check("t6_frozen_x", io.HEAD_X, SX - 1);
`else
        check("t6_collide", io.COLLIDE, 0);
        do_move(0);
        check("t6_moved_x", io.HEAD_X, SX);
`endif

        // Randomised frames with stalls, moves, directions and lengths.
        tick(1'b1, 1'b0, 1'b0);
        rand_tx = 1'b1;
        for (int f = 0; f < 8; f++) begin
            cur_len = $urandom_range(20);
            run_frame(1'b1);
        end

        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
